// File: rtl/isa_bus_arbiter_if.sv
// Requester and ISA pad bundle around the bus arbiter.
// The master modport is the arbiter's view; slave is the requester/pad side.
interface isa_bus_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    req_wr;
   logic [16*NUM_REQ-1:0] req_addr;
   logic [16*NUM_REQ-1:0] req_wdata;
   logic [NUM_REQ-1:0]    grant;
   logic [NUM_REQ-1:0]    ack;
   logic                  err;
   logic [15:0]           rdata;
   logic                  busy;
   logic [15:0]           address;
   logic [15:0]           data_out;
   logic                  data_dir;
   logic                  ior_n;
   logic                  iow_n;
   logic [15:0]           data_in;
   logic                  io_ready;

   modport master (
      input  req, req_wr, req_addr, req_wdata, data_in, io_ready,
      output grant, ack, err, rdata, busy, address, data_out, data_dir, ior_n, iow_n
   );

   modport slave (
      output req, req_wr, req_addr, req_wdata, data_in, io_ready,
      input  grant, ack, err, rdata, busy, address, data_out, data_dir, ior_n, iow_n
   );
endinterface

// File: rtl/isa_bus_arbiter.sv
// Round-robin owner of the ISA I/O bus: one timed SETUP/STROBE/RECOVER cycle per grant,
// ack SETUP+STROBE cycles after the grant edge, stretched by IOCHRDY waits up to a timeout.
module isa_bus_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int SETUP_CYCLES   = 2,
   parameter int STROBE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic          sys_clock,
   input logic          reset_n,
   isa_bus_arbiter_if.master bus
);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int SET_W = $clog2(SETUP_CYCLES) + 1;
   localparam int STB_W = $clog2(STROBE_CYCLES) + 1;
   localparam int WT_W  = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_RECOVER} state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   owner_q, owner_d;
   logic               wr_q, wr_d;
   logic [SET_W-1:0]   setup_cnt_q, setup_cnt_d;
   logic [STB_W-1:0]   strb_cnt_q, strb_cnt_d;
   logic [WT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               err_q, err_d;
   logic [15:0]        rdata_q, rdata_d;
   logic               busy_q, busy_d;
   logic [15:0]        address_q, address_d;
   logic [15:0]        data_out_q, data_out_d;
   logic               data_dir_q, data_dir_d;
   logic               ior_n_q, ior_n_d;
   logic               iow_n_q, iow_n_d;

   logic [PTR_W-1:0]   win;
   logic               any_req;

   // Scan from the pointer downward in priority so the closest set bit wins last.
   always_comb begin
      int idx;
      win     = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = (int'(ptr_q) + i) % NUM_REQ;
         if (bus.req[idx]) begin
            win     = PTR_W'(idx);
            any_req = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      wr_d        = wr_q;
      setup_cnt_d = setup_cnt_q;
      strb_cnt_d  = strb_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      grant_d     = grant_q;
      ack_d       = '0;
      err_d       = 1'b0;
      rdata_d     = rdata_q;
      busy_d      = busy_q;
      address_d   = address_q;
      data_out_d  = data_out_q;
      data_dir_d  = data_dir_q;
      ior_n_d     = ior_n_q;
      iow_n_d     = iow_n_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d     = S_SETUP;
               owner_d     = win;
               wr_d        = bus.req_wr[win];
               grant_d     = NUM_REQ'(1) << win;
               address_d   = bus.req_addr[16*int'(win) +: 16];
               data_out_d  = bus.req_wr[win] ? bus.req_wdata[16*int'(win) +: 16] : 16'h0000;
               data_dir_d  = bus.req_wr[win];
               ptr_d       = (int'(win) == NUM_REQ - 1) ? '0 : win + PTR_W'(1);
               setup_cnt_d = '0;
               busy_d      = 1'b1;
            end
         end
         S_SETUP: begin
            if (setup_cnt_q == SET_W'(SETUP_CYCLES - 1)) begin
               state_d    = S_STROBE;
               strb_cnt_d = '0;
               wait_cnt_d = '0;
               if (wr_q) iow_n_d = 1'b0;
               else      ior_n_d = 1'b0;
            end else begin
               setup_cnt_d = setup_cnt_q + SET_W'(1);
            end
         end
         S_STROBE: begin
            if (strb_cnt_q != STB_W'(STROBE_CYCLES - 1)) begin
               strb_cnt_d = strb_cnt_q + STB_W'(1);
            end else if (bus.io_ready) begin
               state_d        = S_RECOVER;
               ior_n_d        = 1'b1;
               iow_n_d        = 1'b1;
               ack_d[owner_q] = 1'b1;
               if (!wr_q) rdata_d = bus.data_in;
            end else if (wait_cnt_q == WT_W'(TIMEOUT_CYCLES)) begin
               // Target never released IOCHRDY: abort with a recognisable read value.
               state_d        = S_RECOVER;
               ior_n_d        = 1'b1;
               iow_n_d        = 1'b1;
               ack_d[owner_q] = 1'b1;
               err_d          = 1'b1;
               if (!wr_q) rdata_d = 16'hFFFF;
            end else begin
               wait_cnt_d = wait_cnt_q + WT_W'(1);
            end
         end
         S_RECOVER: begin
            state_d    = S_IDLE;
            grant_d    = '0;
            data_dir_d = 1'b0;
            busy_d     = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clock) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         wr_q        <= 1'b0;
         setup_cnt_q <= '0;
         strb_cnt_q  <= '0;
         wait_cnt_q  <= '0;
         grant_q     <= '0;
         ack_q       <= '0;
         err_q       <= 1'b0;
         rdata_q     <= 16'h0000;
         busy_q      <= 1'b0;
         address_q   <= 16'h0000;
         data_out_q  <= 16'h0000;
         data_dir_q  <= 1'b0;
         ior_n_q     <= 1'b1;
         iow_n_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         wr_q        <= wr_d;
         setup_cnt_q <= setup_cnt_d;
         strb_cnt_q  <= strb_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         grant_q     <= grant_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         busy_q      <= busy_d;
         address_q   <= address_d;
         data_out_q  <= data_out_d;
         data_dir_q  <= data_dir_d;
         ior_n_q     <= ior_n_d;
         iow_n_q     <= iow_n_d;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.ack      = ack_q;
   assign bus.err      = err_q;
   assign bus.rdata    = rdata_q;
   assign bus.busy     = busy_q;
   assign bus.address  = address_q;
   assign bus.data_out = data_out_q;
   assign bus.data_dir = data_dir_q;
   assign bus.ior_n    = ior_n_q;
   assign bus.iow_n    = iow_n_q;
endmodule

// File: tb/tb_isa_bus_arbiter.sv
// Random accesses against a cycle-timeline model of the ISA arbiter: round-robin winner,
// setup/strobe/recover phases, IOCHRDY waits, timeout abort and mid-access reset.
module tb_isa_bus_arbiter;
   localparam int N  = 4;
   localparam int S  = 2;
   localparam int T  = 4;
   localparam int TO = 64;

   logic sys_clock = 1'b0;
   logic reset_n   = 1'b0;

   isa_bus_arbiter_if #(.NUM_REQ(N)) bus ();

   isa_bus_arbiter #(
      .NUM_REQ(N), .SETUP_CYCLES(S), .STROBE_CYCLES(T), .TIMEOUT_CYCLES(TO)
   ) dut (
      .sys_clock (sys_clock),
      .reset_n   (reset_n),
      .bus       (bus)
   );

   always #5 sys_clock = ~sys_clock;

   int checks = 0;
   int errors = 0;

   int          ptr_m   = 0;
   logic [15:0] rdata_m = 16'h0000;
   logic [15:0] a_m [N];
   logic [15:0] d_m [N];
   logic        wr_m[N];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic chk_outs(input string ph, input logic [N-1:0] g, input logic [N-1:0] a,
                           input logic e, input logic b, input logic dir,
                           input logic rn, input logic wn, input bit chk_ad,
                           input logic [15:0] ea, input logic [15:0] ed);
      chk({ph, ".grant"}, 32'(bus.grant), 32'(g));
      chk({ph, ".ack"},   32'(bus.ack),   32'(a));
      chk({ph, ".err"},   32'(bus.err),   32'(e));
      chk({ph, ".busy"},  32'(bus.busy),  32'(b));
      chk({ph, ".dir"},   32'(bus.data_dir), 32'(dir));
      chk({ph, ".ior_n"}, 32'(bus.ior_n), 32'(rn));
      chk({ph, ".iow_n"}, 32'(bus.iow_n), 32'(wn));
      chk({ph, ".rdata"}, 32'(bus.rdata), 32'(rdata_m));
      if (chk_ad) begin
         chk({ph, ".addr"}, 32'(bus.address),  32'(ea));
         chk({ph, ".dout"}, 32'(bus.data_out), 32'(ed));
      end
   endtask

   task automatic set_fields();
      for (int i = 0; i < N; i++) begin
         a_m[i]  = 16'($urandom);
         d_m[i]  = 16'($urandom);
         wr_m[i] = 1'($urandom_range(1));
         bus.req_addr[16*i +: 16]  = a_m[i];
         bus.req_wdata[16*i +: 16] = d_m[i];
         bus.req_wr[i]             = wr_m[i];
      end
   endtask

   // Called at a negedge while the arbiter is idle; returns at the negedge of the idle cycle after ack.
   task automatic run_txn(input int id, input logic [N-1:0] rq, input int waits, input bit tmo,
                          input int fwr);
      int          w, len, term, nz;
      logic [15:0] ea, ed, din_cap;
      logic        ew;
      string       ph;
      set_fields();
      bus.req = rq;
      w = -1;
      for (int i = 0; i < N; i++)
         if (w < 0 && rq[(ptr_m + i) % N]) w = (ptr_m + i) % N;
      if (fwr >= 0) begin
         wr_m[w] = 1'(fwr);
         bus.req_wr[w] = wr_m[w];
      end
      ptr_m   = (w + 1) % N;
      ea      = a_m[w];
      ew      = wr_m[w];
      ed      = ew ? d_m[w] : 16'h0000;
      term    = S + T - 1;
      nz      = tmo ? TO + 1 : waits;
      len     = S + T + (tmo ? TO : waits);
      din_cap = 16'h0000;
      for (int j = 0; j <= len + 1; j++) begin
         @(negedge sys_clock);
         ph = $sformatf("t%0d.c%0d", id, j);
         if (j == len) begin
            if (tmo) begin
               if (!ew) rdata_m = 16'hFFFF;
            end else if (!ew) begin
               rdata_m = din_cap;
            end
         end
         chk_outs(ph,
                  (j <= len) ? N'(1) << w : '0,
                  (j == len) ? N'(1) << w : '0,
                  (j == len) && tmo,
                  j <= len,
                  (j <= len) && ew,
                  !(!ew && j >= S && j < len),
                  !(ew && j >= S && j < len),
                  j <= len, ea, ed);
         if (j == 0) begin
            set_fields();
            if ($urandom_range(1) == 1) bus.req[w] = 1'b0;
         end
         bus.data_in = 16'($urandom);
         if (j == len - 1) din_cap = bus.data_in;
         if (j >= term && j < term + nz) bus.io_ready = 1'b0;
         else if (j == term + nz)        bus.io_ready = 1'b1;
         else                            bus.io_ready = 1'($urandom_range(1));
      end
   endtask

   initial begin
      logic [N-1:0] rq;
      int           waits, fwr;
      bit           tmo;
      bus.req       = '0;
      bus.req_wr    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.data_in   = 16'h0000;
      bus.io_ready  = 1'b1;
      repeat (3) @(negedge sys_clock);
      chk_outs("reset", '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
      reset_n = 1'b1;
      @(negedge sys_clock);
      chk_outs("idle", '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);

      for (int t = 0; t < 40; t++) begin
         rq    = N'($urandom_range(1, (1 << N) - 1));
         waits = ($urandom_range(3) == 0) ? int'($urandom_range(1, 12)) : 0;
         tmo   = 1'b0;
         fwr   = -1;
         if (t < 5) begin
            rq    = '1;
            waits = 0;
         end
         if (t == 5) begin waits = 10; fwr = 1; end
         if (t == 6) begin tmo = 1'b1; fwr = 0; end
         if (t == 7) begin tmo = 1'b1; fwr = 1; end
         if (t == 8) fwr = 0;
         run_txn(t, rq, waits, tmo, fwr);
      end

      // Abort an access mid-strobe, from a requester that leaves the pointer non-zero.
      bus.req = '0;
      @(negedge sys_clock);
      set_fields();
      bus.req = 4'b0100;
      repeat (S + 2) @(negedge sys_clock);
      reset_n = 1'b0;
      bus.req = '0;
      @(negedge sys_clock);
      rdata_m = 16'h0000;
      ptr_m   = 0;
      chk_outs("midrst", '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
      reset_n = 1'b1;
      @(negedge sys_clock);
      chk_outs("postrst", '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
      run_txn(100, '1, 0, 1'b0, 0);
      run_txn(101, '1, 3, 1'b0, -1);
      bus.req = '0;
      @(negedge sys_clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
